cpu_debug_ocimem_arbiter: RTL

Shares the CPU's on-chip debug memory (OCI RAM, 256 x 32, one-cycle read latency) between two requesters: the JTAG debug-slave command path and the Avalon debug_mem_slave port. JTAG requests arrive as single-cycle system-clock strobes with a 38-bit `jdo` payload. Avalon requests are held under `avl_waitrequest`. The block sits between the debug-slave wrapper outputs and the OCI RAM. It arbitrates round-robin, owns the JTAG auto-incrementing address, and returns read data to the JTAG monitor register.

---
 rtl/cpu_debug_ocimem_arbiter_pkg.sv | 18 +
 rtl/cpu_debug_ocimem_arbiter_if.sv | 26 ++
 rtl/cpu_debug_ocimem_jtag_req.sv | 57 +++++
 rtl/cpu_debug_ocimem_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cpu_debug_ocimem_arbiter_pkg.sv
// cpu_debug_pkg: shared OCI RAM widths, jdo field positions and arbiter state encoding
package cpu_debug_pkg;
    localparam int OCI_ADDR_W    = 8;
    localparam int OCI_DATA_W    = 32;
    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_HI   = 33;
    localparam int JDO_ADDR_LO   = 26;
    localparam int JDO_WDATA_HI  = 34;
    localparam int JDO_WDATA_LO  = 3;
    localparam int JDO_RDREQ_BIT = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_JRD,
        ST_AVL_RD,
        ST_AVL_ACK
    } ocimem_state_t;
endpackage

// File: rtl/cpu_debug_ocimem_arbiter_if.sv
// cpu_debug_ocimem_arbiter_if: Avalon debug_mem_slave bus between the debug master and the arbiter
interface cpu_debug_ocimem_arbiter_if
    import cpu_debug_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W,
    parameter int DATA_W = OCI_DATA_W
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                debugaccess;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;

    modport master (
        output address, read, write, writedata, byteenable, debugaccess,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable, debugaccess,
        output readdata, waitrequest
    );
endinterface

// File: rtl/cpu_debug_ocimem_jtag_req.sv
// cpu_debug_ocimem_jtag_req: one-deep JTAG request latch, sticky overrun flag and wrapping address counter
module cpu_debug_ocimem_jtag_req
    import cpu_debug_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W,
    parameter int DATA_W = OCI_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              done,
    output logic              pending,
    output logic              is_write,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] addr,
    output logic              overrun
);
    logic req;
    logic req_wr;
    logic losers;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_WDATA_HI+1], jdo[JDO_WDATA_LO-1:0]};

    // strobe a wins over b, b over no_action; a without its read bit still claims the slot
    always_comb begin
        req    = take_action_ocimem_a ? jdo[JDO_RDREQ_BIT] : (take_action_ocimem_b | take_no_action_ocimem_a);
        req_wr = !take_action_ocimem_a & take_action_ocimem_b;
        losers = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
               | (take_action_ocimem_b & take_no_action_ocimem_a);
    end

    // pending request, overrun and address; an address load beats the post-service increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 1'b0;
            is_write <= 1'b0;
            wdata    <= '0;
            addr     <= '0;
            overrun  <= 1'b0;
        end else begin
            pending <= pending ? !done : req;
            if (!pending && req) begin
                is_write <= req_wr;
                wdata    <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
            end
            overrun <= overrun | losers | (req & pending);
            if (take_action_ocimem_a)
                addr <= jdo[JDO_ADDR_HI:JDO_ADDR_LO];
            else if (done)
                addr <= addr + ADDR_W'(1);
        end
    end
endmodule

// File: rtl/cpu_debug_ocimem_arbiter.sv
// cpu_debug_ocimem_arbiter: round-robin sharing of the OCI RAM between JTAG debug commands and Avalon
module cpu_debug_ocimem_arbiter
    import cpu_debug_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W,
    parameter int DATA_W = OCI_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [JDO_W-1:0]          jdo,
    input  logic                      take_action_ocimem_a,
    input  logic                      take_no_action_ocimem_a,
    input  logic                      take_action_ocimem_b,
    output logic [DATA_W-1:0]         MonDReg,
    output logic                      jtag_busy,
    output logic                      ocimem_overrun,
    cpu_debug_ocimem_arbiter_if.slave avl,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic [DATA_W/8-1:0]       ram_be,
    output logic                      ram_we,
    output logic                      ram_re,
    input  logic [DATA_W-1:0]         ram_rdata
);
    ocimem_state_t state;
    ocimem_state_t next;
    logic              last_jtag;
    logic              grant_j;
    logic              grant_a;
    logic              done;
    logic              j_pending;
    logic              j_write;
    logic [DATA_W-1:0] j_wdata;
    logic [ADDR_W-1:0] j_addr;
    logic [DATA_W-1:0] rdata_q;

    cpu_debug_ocimem_jtag_req #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_jtag_req (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .done                    (done),
        .pending                 (j_pending),
        .is_write                (j_write),
        .wdata                   (j_wdata),
        .addr                    (j_addr),
        .overrun                 (ocimem_overrun)
    );

    assign jtag_busy       = j_pending;
    assign avl.readdata    = rdata_q;
    assign avl.waitrequest = (state != ST_AVL_ACK);

    // arbitration in IDLE drives the RAM port combinationally; grants are held off during reset
    always_comb begin
        next      = state;
        grant_j   = 1'b0;
        grant_a   = 1'b0;
        done      = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_be    = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            ST_IDLE: if (reset_n) begin
                grant_j = j_pending & (!(avl.read | avl.write) | !last_jtag);
                grant_a = (avl.read | avl.write) & !grant_j;
                if (grant_j) begin
                    ram_addr = j_addr;
                    if (j_write) begin
                        ram_we    = 1'b1;
                        ram_be    = '1;
                        ram_wdata = j_wdata;
                        done      = 1'b1;
                    end else begin
                        ram_re = 1'b1;
                        next   = ST_JRD;
                    end
                end else if (grant_a) begin
                    ram_addr = avl.address;
                    if (avl.read) begin
                        ram_re = 1'b1;
                        next   = ST_AVL_RD;
                    end else begin
                        ram_we    = avl.debugaccess;
                        ram_be    = avl.byteenable;
                        ram_wdata = avl.writedata;
                        next      = ST_AVL_ACK;
                    end
                end
            end
            ST_JRD: begin
                done = 1'b1;
                next = ST_IDLE;
            end
            ST_AVL_RD: next = ST_AVL_ACK;
            default:   next = ST_IDLE;
        endcase
    end

    // state, last-grant memory and read-data capture registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            last_jtag <= 1'b0;
            MonDReg   <= '0;
            rdata_q   <= '0;
        end else begin
            state <= next;
            if (grant_j || grant_a)
                last_jtag <= grant_j;
            if (state == ST_JRD)
                MonDReg <= ram_rdata;
            if (state == ST_AVL_RD)
                rdata_q <= ram_rdata;
        end
    end
endmodule
